// File: rtl/seg_memory_pkg.sv
// Shared MEM-stage definitions: pipeline widths and control-bit positions
// common with the control unit and seg_execute.
package seg_memory_pkg;

  localparam int NB_ADDR    = 32;
  localparam int NB_DATA    = 32;
  localparam int NB_REG     = 5;
  localparam int NB_DEPTH   = 10;
  localparam int NB_CTRL_WB = 2;
  localparam int NB_CTRL_M  = 3;
  localparam int NB_CTRL    = NB_CTRL_WB + NB_CTRL_M;

  // Bit positions inside the M field {branch, mem_read, mem_write}
  localparam int CTRL_BRANCH    = 2;
  localparam int CTRL_MEM_READ  = 1;
  localparam int CTRL_MEM_WRITE = 0;

  // Bit positions inside the WB field {reg_write, mem_to_reg}
  localparam int CTRL_REG_WRITE  = 1;
  localparam int CTRL_MEM_TO_REG = 0;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } ctrl_wb_t;

  function automatic logic [NB_DEPTH-1:0] word_index(input logic [NB_DATA-1:0] byte_addr);
    return byte_addr[NB_DEPTH+1:2];
  endfunction

endpackage

// File: rtl/seg_memory_if.sv
// EX/MEM inputs and MEM/WB outputs of the MEM stage, plus the debug read port.
interface seg_memory_if;
  import seg_memory_pkg::*;

  logic [NB_ADDR-1:0]  i_PC_branch;
  logic [NB_DATA-1:0]  i_ALU_result;
  logic                i_ALU_zero;
  logic [NB_DATA-1:0]  i_read_data_2;
  logic [NB_REG-1:0]   i_write_reg;
  logic [NB_CTRL-1:0]  i_control;
  logic [NB_DEPTH-1:0] i_dbg_addr;

  logic                o_PC_src;
  logic [NB_ADDR-1:0]  o_PC_branch;
  logic [NB_DATA-1:0]  o_read_data;
  logic [NB_DATA-1:0]  o_ALU_result;
  logic [NB_REG-1:0]   o_write_reg;
  logic [NB_CTRL_WB-1:0] o_control;
  logic                o_misaligned;
  logic [NB_DATA-1:0]  o_dbg_data;

  modport master (
    output i_PC_branch, i_ALU_result, i_ALU_zero, i_read_data_2, i_write_reg, i_control, i_dbg_addr,
    input  o_PC_src, o_PC_branch, o_read_data, o_ALU_result, o_write_reg, o_control, o_misaligned,
           o_dbg_data
  );

  modport slave (
    input  i_PC_branch, i_ALU_result, i_ALU_zero, i_read_data_2, i_write_reg, i_control, i_dbg_addr,
    output o_PC_src, o_PC_branch, o_read_data, o_ALU_result, o_write_reg, o_control, o_misaligned,
           o_dbg_data
  );

endinterface

// File: rtl/seg_memory_data_memory.sv
// Word-addressed data RAM: one synchronous write port, one registered read port
// and an asynchronous debug read port.
module data_memory #(
  parameter int NB_DATA  = 32,
  parameter int NB_DEPTH = 10
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [NB_DEPTH-1:0] wr_addr,
  input  logic [NB_DATA-1:0]  wr_data,
  input  logic                rd_en,
  input  logic [NB_DEPTH-1:0] rd_addr,
  output logic [NB_DATA-1:0]  rd_data,
  input  logic [NB_DEPTH-1:0] dbg_addr,
  output logic [NB_DATA-1:0]  dbg_data
);

  logic [NB_DATA-1:0] mem [2**NB_DEPTH];
  logic [NB_DATA-1:0] rd_data_reg;

  // No reset: RAM contents and the read register survive pipeline reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data  = rd_data_reg;
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/seg_memory.sv
// MIPS MEM stage: data RAM access, taken-branch decision for IF, misalignment
// flag and the MEM/WB pipeline register.
module seg_memory
  import seg_memory_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  seg_memory_if.slave  bus
);

  logic                mem_read;
  logic                mem_write;
  logic                branch;
  logic [NB_DEPTH-1:0] word_idx;
  logic                ram_wr_en;
  logic                ram_rd_en;
  logic [NB_DATA-1:0]  ram_rd_data;

  logic [NB_DATA-1:0]  alu_result_reg;
  logic [NB_REG-1:0]   write_reg_reg;
  ctrl_wb_t            control_reg;
  logic                misaligned_reg;
  logic                read_valid_reg;

  assign mem_read  = bus.i_control[CTRL_MEM_READ];
  assign mem_write = bus.i_control[CTRL_MEM_WRITE];
  assign branch    = bus.i_control[CTRL_BRANCH];
  assign word_idx  = word_index(bus.i_ALU_result);

  // Write wins over an illegal simultaneous read; nothing touches RAM in reset.
  assign ram_wr_en = i_rst & mem_write;
  assign ram_rd_en = i_rst & mem_read & ~mem_write;

  data_memory #(
    .NB_DATA  (NB_DATA),
    .NB_DEPTH (NB_DEPTH)
  ) u_data_memory (
    .clk      (i_clk),
    .wr_en    (ram_wr_en),
    .wr_addr  (word_idx),
    .wr_data  (bus.i_read_data_2),
    .rd_en    (ram_rd_en),
    .rd_addr  (word_idx),
    .rd_data  (ram_rd_data),
    .dbg_addr (bus.i_dbg_addr),
    .dbg_data (bus.o_dbg_data)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      alu_result_reg <= '0;
      write_reg_reg  <= '0;
      control_reg    <= '0;
      misaligned_reg <= 1'b0;
      read_valid_reg <= 1'b0;
    end else begin
      alu_result_reg <= bus.i_ALU_result;
      write_reg_reg  <= bus.i_write_reg;
      control_reg    <= ctrl_wb_t'(bus.i_control[NB_CTRL-1:NB_CTRL_M]);
      misaligned_reg <= (mem_read | mem_write) & (bus.i_ALU_result[1:0] != 2'b00);
      read_valid_reg <= ram_rd_en;
    end
  end

  // The RAM read register has no reset, so a valid flag masks it to zero.
  assign bus.o_read_data  = read_valid_reg ? ram_rd_data : '0;
  assign bus.o_ALU_result = alu_result_reg;
  assign bus.o_write_reg  = write_reg_reg;
  assign bus.o_control    = control_reg;
  assign bus.o_misaligned = misaligned_reg;

  assign bus.o_PC_src    = branch & bus.i_ALU_zero;
  assign bus.o_PC_branch = bus.i_PC_branch;

endmodule

// File: tb/tb_seg_memory.sv
// Self-checking bench for seg_memory: directed vector table, reset-in-flight
// sequence and randomized traffic against a word-array reference model.
module tb_seg_memory;
  import seg_memory_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  seg_memory_if bus();

  seg_memory dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the RAM as a plain word array, with a flag per word
  // recording whether the bench has ever written it.
  logic [31:0] ref_mem   [1024];
  bit          ref_known [1024];

  typedef struct {
    logic [4:0]  ctrl;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  wreg;
    logic        zero;
    logic [31:0] exp_rd;
    logic        exp_mis;
    logic        exp_pcsrc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One pipeline cycle: drive at negedge, check combinational branch outputs,
  // then check the MEM/WB register just after the rising edge.
  task automatic step(input logic [4:0] ctrl, input logic [31:0] alu, input logic [31:0] wdata,
                      input logic [4:0] wreg, input logic zero, input logic [31:0] pcb,
                      input logic exp_pcsrc, input bit rd_known, input logic [31:0] exp_rd,
                      input logic exp_mis);
    int idx;
    @(negedge clk);
    bus.i_control     = ctrl;
    bus.i_ALU_result  = alu;
    bus.i_read_data_2 = wdata;
    bus.i_write_reg   = wreg;
    bus.i_ALU_zero    = zero;
    bus.i_PC_branch   = pcb;
    #1;
    chk("pc_src", {31'd0, bus.o_PC_src}, {31'd0, exp_pcsrc});
    chk("pc_branch", bus.o_PC_branch, pcb);
    @(posedge clk);
    #1;
    chk("alu_result", bus.o_ALU_result, alu);
    chk("write_reg", {27'd0, bus.o_write_reg}, {27'd0, wreg});
    chk("control", {30'd0, bus.o_control}, {30'd0, ctrl[4:3]});
    chk("misaligned", {31'd0, bus.o_misaligned}, {31'd0, exp_mis});
    if (rd_known) chk("read_data", bus.o_read_data, exp_rd);
    idx = (alu / 4) % 1024;
    if (ctrl[0]) begin
      ref_mem[idx]   = wdata;
      ref_known[idx] = 1'b1;
    end
  endtask

  task automatic chk_dbg(input string name, input int addr, input logic [31:0] exp);
    bus.i_dbg_addr = addr[9:0];
    #1;
    chk(name, bus.o_dbg_data, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_read_data"}, bus.o_read_data, 32'd0);
    chk({tag, "_alu_result"}, bus.o_ALU_result, 32'd0);
    chk({tag, "_write_reg"}, {27'd0, bus.o_write_reg}, 32'd0);
    chk({tag, "_control"}, {30'd0, bus.o_control}, 32'd0);
    chk({tag, "_misaligned"}, {31'd0, bus.o_misaligned}, 32'd0);
  endtask

  vec_t vecs[11];

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 1024; i++) ref_known[i] = 1'b0;

    //          ctrl       alu           wdata         wreg  z  exp_rd        mis pcsrc
    vecs[0]  = '{5'b00_001, 32'h0000_0010, 32'hDEAD_BEEF, 5'd1, 0, 32'h0,         0, 0};
    vecs[1]  = '{5'b11_010, 32'h0000_0010, 32'h0,         5'd2, 0, 32'hDEAD_BEEF, 0, 0};
    vecs[2]  = '{5'b01_001, 32'h0000_1000, 32'h1234_5678, 5'd3, 0, 32'h0,         0, 0};
    vecs[3]  = '{5'b11_010, 32'h0000_0013, 32'h0,         5'd4, 0, 32'hDEAD_BEEF, 1, 0};
    vecs[4]  = '{5'b10_000, 32'h0000_0055, 32'h0,         5'd5, 0, 32'h0,         0, 0};
    vecs[5]  = '{5'b00_100, 32'h0000_0000, 32'h0,         5'd6, 1, 32'h0,         0, 1};
    vecs[6]  = '{5'b00_100, 32'h0000_0004, 32'h0,         5'd7, 0, 32'h0,         0, 0};
    vecs[7]  = '{5'b00_000, 32'h0000_0000, 32'h0,         5'd8, 1, 32'h0,         0, 0};
    vecs[8]  = '{5'b10_011, 32'h0000_0020, 32'hA5A5_A5A5, 5'd7, 0, 32'h0,         0, 0};
    vecs[9]  = '{5'b11_010, 32'h0000_0020, 32'h0,         5'd9, 0, 32'hA5A5_A5A5, 0, 0};
    vecs[10] = '{5'b11_010, 32'hFFFF_F000, 32'h0,         5'd10, 0, 32'h1234_5678, 0, 0};

    bus.i_control     = '0;
    bus.i_ALU_result  = '0;
    bus.i_read_data_2 = '0;
    bus.i_write_reg   = '0;
    bus.i_ALU_zero    = 1'b0;
    bus.i_PC_branch   = '0;
    bus.i_dbg_addr    = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].ctrl, vecs[i].alu, vecs[i].wdata, vecs[i].wreg, vecs[i].zero,
           32'h0040_0000 + 32'(i * 4), vecs[i].exp_pcsrc, 1'b1, vecs[i].exp_rd, vecs[i].exp_mis);
      $display("vec %0d ctrl=%b alu=%h rd=%h mis=%b", i, vecs[i].ctrl, vecs[i].alu,
               bus.o_read_data, bus.o_misaligned);
    end
    chk_dbg("dbg_word4", 4, 32'hDEAD_BEEF);
    chk_dbg("dbg_word0", 0, 32'h1234_5678);
    chk_dbg("dbg_word8", 8, 32'hA5A5_A5A5);

    // Reset asserted mid-cycle while a store is presented.
    step(5'b11_010, 32'h0000_0011, 32'h0, 5'd12, 0, 32'h0, 0, 1'b1, 32'hDEAD_BEEF, 1);
    @(negedge clk);
    bus.i_control     = 5'b11_001;
    bus.i_ALU_result  = 32'h0000_0010;
    bus.i_read_data_2 = 32'h1111_1111;
    bus.i_write_reg   = 5'd13;
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("rst_async");
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("rst_held");
    chk_dbg("rst_dbg_word4", 4, 32'hDEAD_BEEF);
    $display("reset in flight: dbg[4]=%h", bus.o_dbg_data);
    @(negedge clk);
    bus.i_control = '0;
    rst = 1'b1;

    // Randomized traffic over a small word window so loads often hit written words.
    for (int n = 0; n < 300; n++) begin
      logic [4:0]  ctrl;
      logic [31:0] alu;
      logic [31:0] wdata;
      logic        zero;
      logic        mr;
      logic        mw;
      logic [1:0]  lo;
      int          idx;
      bit          known;
      logic [31:0] exp_rd;
      ctrl  = 5'($urandom_range(0, 31));
      lo    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      alu   = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 15) * 4) | {30'd0, lo};
      wdata = $urandom();
      zero  = 1'($urandom_range(0, 1));
      mr    = ctrl[1];
      mw    = ctrl[0];
      idx   = (alu / 4) % 1024;
      known = 1'b1;
      exp_rd = 32'd0;
      if (mr && !mw) begin
        known  = ref_known[idx];
        exp_rd = ref_mem[idx];
      end
      step(ctrl, alu, wdata, 5'($urandom_range(0, 31)), zero, $urandom(),
           ctrl[2] & zero, known, exp_rd, (mr | mw) & (lo != 2'b00));
      $display("rand %0d ctrl=%b alu=%h rd=%h", n, ctrl, alu, bus.o_read_data);
      if (ref_known[n % 16]) chk_dbg("rand_dbg", n % 16, ref_mem[n % 16]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
